// File: rtl/id_ex_issue_buf_pkg.sv
// Shared decode-bundle layout and hold-code level for the ID/EX issue buffer.
// PAYLOAD width is derived from the field map below.
package id_ex_issue_buf_pkg;

   localparam int BUS_RS1_LSB   = 0;
   localparam int BUS_RS1_W     = 64;
   localparam int BUS_RS2_LSB   = BUS_RS1_LSB + BUS_RS1_W;
   localparam int BUS_RS2_W     = 64;
   localparam int BUS_RD_LSB    = BUS_RS2_LSB + BUS_RS2_W;
   localparam int BUS_RD_W      = 5;
   localparam int BUS_ALU_LSB   = BUS_RD_LSB + BUS_RD_W;
   localparam int BUS_ALU_W     = 6;
   localparam int BUS_LS_LSB    = BUS_ALU_LSB + BUS_ALU_W;
   localparam int BUS_LS_W      = 4;
   localparam int BUS_CSRA_LSB  = BUS_LS_LSB + BUS_LS_W;
   localparam int BUS_CSRA_W    = 12;
   localparam int BUS_CSROP_LSB = BUS_CSRA_LSB + BUS_CSRA_W;
   localparam int BUS_CSROP_W   = 3;
   localparam int BUS_IADDR_LSB = BUS_CSROP_LSB + BUS_CSROP_W;
   localparam int BUS_IADDR_W   = 64;
   // Spare bits pad the bundle to a round 256 for the downstream latch.
   localparam int BUS_RSVD_LSB  = BUS_IADDR_LSB + BUS_IADDR_W;
   localparam int BUS_RSVD_W    = 34;
   localparam int BUS_PAYLOAD_W = BUS_RSVD_LSB + BUS_RSVD_W;

   localparam logic [2:0] HOLD_CODE_ID = 3'd2;

   typedef logic [BUS_PAYLOAD_W-1:0] id_ex_bus_t;

   function automatic logic hold_from_code(input logic [2:0] hold_code);
      return hold_code >= HOLD_CODE_ID;
   endfunction

endpackage

// File: rtl/id_ex_issue_ram.sv
// DEPTH x PAYLOAD_W register array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module id_ex_issue_ram #(
   parameter int PAYLOAD_W = 256,
   parameter int DEPTH     = 2,
   parameter int PTR_W     = 1
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [PTR_W-1:0]     wr_addr,
   input  logic [PAYLOAD_W-1:0] wr_data,
   input  logic [PTR_W-1:0]     rd_addr,
   output logic [PAYLOAD_W-1:0] rd_data
);

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [PAYLOAD_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/id_ex_issue_buf.sv
// DEPTH-entry decoded-instruction queue between ID and EX with flush, hold and
// optional empty fall-through. Define ID_EX_ISSUE_PERF_EN for stall/full/flush counters.
module id_ex_issue_buf
   import id_ex_issue_buf_pkg::*;
#(
   parameter int PAYLOAD_W   = BUS_PAYLOAD_W,
   parameter int DEPTH       = 2,
   parameter int FALLTHROUGH = 0,
   parameter int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 hold,
   input  logic                 flush,
   output logic [CNT_W-1:0]     count
`ifdef ID_EX_ISSUE_PERF_EN
   ,
   output logic [31:0]          perf_stall_cnt,
   output logic [31:0]          perf_full_cnt,
   output logic [31:0]          perf_flush_cnt
`endif
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 empty, bypass, push, pop, wr_en, rd_en;
   logic [PAYLOAD_W-1:0] head_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (count_q == '0);
   assign in_ready  = (count_q != CNT_FULL);
   assign bypass    = (FALLTHROUGH != 0) && empty;
   assign out_valid = bypass ? (in_valid & ~flush) : ~empty;
   assign out_data  = out_valid ? (bypass ? in_data : head_data) : '0;
   assign count     = count_q;

   assign push  = in_valid & in_ready & ~flush;
   assign pop   = out_valid & out_ready & ~hold & ~flush;
   // A bundle consumed straight through an empty queue never touches storage.
   assign wr_en = push & ~(bypass & pop);
   assign rd_en = pop & ~bypass;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
         else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   id_ex_issue_ram #(
      .PAYLOAD_W (PAYLOAD_W),
      .DEPTH     (DEPTH),
      .PTR_W     (PTR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_ptr_q),
      .rd_data (head_data)
   );

`ifdef ID_EX_ISSUE_PERF_EN
   logic [31:0] stall_q, stall_d, full_q, full_d, fl_q, fl_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != '1)) ? v + 32'd1 : v;
   endfunction

   always_comb begin
      stall_d = sat_inc(stall_q, out_valid & (~out_ready | hold));
      full_d  = sat_inc(full_q, in_valid & ~in_ready);
      fl_d    = sat_inc(fl_q, flush & ~empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         full_q  <= '0;
         fl_q    <= '0;
      end else begin
         stall_q <= stall_d;
         full_q  <= full_d;
         fl_q    <= fl_d;
      end
   end

   assign perf_stall_cnt = stall_q;
   assign perf_full_cnt  = full_q;
   assign perf_flush_cnt = fl_q;
`endif

endmodule

// File: tb/tb_id_ex_issue_buf.sv
// Bench for id_ex_issue_buf: DEPTH=2, DEPTH=3 and DEPTH=2 fall-through instances
// driven in parallel and compared each cycle against a shift-array queue model.
module tb_id_ex_issue_buf;
   import id_ex_issue_buf_pkg::*;

   localparam int W = BUS_PAYLOAD_W;
   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready, hold, flush;
   logic [W-1:0] in_data;

   logic         in_ready_w  [N];
   logic         out_valid_w [N];
   logic [W-1:0] out_data_w  [N];
   logic [1:0]   count_w     [N];
`ifdef ID_EX_ISSUE_PERF_EN
   logic [31:0]  pstall_w [N];
   logic [31:0]  pfull_w  [N];
   logic [31:0]  pflush_w [N];
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model: entry 0 is always the head; a pop shifts everything down.
   logic [W-1:0] mq [N][8];
   int           mcnt [N];
   logic [31:0]  mstall [N];
   logic [31:0]  mfull  [N];
   logic [31:0]  mflush [N];

   always #5 clk = ~clk;

   id_ex_issue_buf #(.DEPTH(2), .FALLTHROUGH(0)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_data(in_data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
      .out_data(out_data_w[0]), .hold(hold), .flush(flush), .count(count_w[0])
`ifdef ID_EX_ISSUE_PERF_EN
      , .perf_stall_cnt(pstall_w[0]), .perf_full_cnt(pfull_w[0]), .perf_flush_cnt(pflush_w[0])
`endif
   );

   id_ex_issue_buf #(.DEPTH(3), .FALLTHROUGH(0)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_data(in_data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
      .out_data(out_data_w[1]), .hold(hold), .flush(flush), .count(count_w[1])
`ifdef ID_EX_ISSUE_PERF_EN
      , .perf_stall_cnt(pstall_w[1]), .perf_full_cnt(pfull_w[1]), .perf_flush_cnt(pflush_w[1])
`endif
   );

   id_ex_issue_buf #(.DEPTH(2), .FALLTHROUGH(1)) u_ft (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_data(in_data), .out_valid(out_valid_w[2]), .out_ready(out_ready),
      .out_data(out_data_w[2]), .hold(hold), .flush(flush), .count(count_w[2])
`ifdef ID_EX_ISSUE_PERF_EN
      , .perf_stall_cnt(pstall_w[2]), .perf_full_cnt(pfull_w[2]), .perf_flush_cnt(pflush_w[2])
`endif
   );

   function automatic int dep_of(input int k);
      return (k == 1) ? 3 : 2;
   endfunction

   function automatic bit ft_of(input int k);
      return (k == 2);
   endfunction

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic drv(input bit iv, input logic [W-1:0] d, input bit ordy, input bit h, input bit fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      hold      = h;
      flush     = fl;
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycle(input bit chk);
      bit ov [N];
      bit pop, push;
      #2;
      for (int k = 0; k < N; k++) begin
         ov[k] = (mcnt[k] != 0) || (ft_of(k) && in_valid && !flush);
         if (chk) begin
            check_eq($sformatf("d%0d_in_ready", k), W'(in_ready_w[k]), W'(mcnt[k] != dep_of(k)));
            check_eq($sformatf("d%0d_out_valid", k), W'(out_valid_w[k]), W'(ov[k]));
            check_eq($sformatf("d%0d_count", k), W'(count_w[k]), W'(mcnt[k]));
            if (ov[k])
               check_eq($sformatf("d%0d_out_data", k), out_data_w[k],
                        (mcnt[k] != 0) ? mq[k][0] : in_data);
`ifdef ID_EX_ISSUE_PERF_EN
            check_eq($sformatf("d%0d_perf_stall", k), W'(pstall_w[k]), W'(mstall[k]));
            check_eq($sformatf("d%0d_perf_full", k), W'(pfull_w[k]), W'(mfull[k]));
            check_eq($sformatf("d%0d_perf_flush", k), W'(pflush_w[k]), W'(mflush[k]));
`endif
         end
      end
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (rst) begin
            mcnt[k]   = 0;
            mstall[k] = '0;
            mfull[k]  = '0;
            mflush[k] = '0;
         end else begin
            if (ov[k] && (!out_ready || hold) && mstall[k] != '1) mstall[k]++;
            if (in_valid && mcnt[k] == dep_of(k) && mfull[k] != '1) mfull[k]++;
            if (flush && mcnt[k] != 0 && mflush[k] != '1) mflush[k]++;
            if (flush) begin
               mcnt[k] = 0;
            end else begin
               pop  = ov[k] && out_ready && !hold;
               push = in_valid && (mcnt[k] != dep_of(k));
               if (!(pop && mcnt[k] == 0)) begin
                  if (pop) begin
                     for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                     mcnt[k]--;
                  end
                  if (push) begin
                     mq[k][mcnt[k]] = in_data;
                     mcnt[k]++;
                  end
               end
            end
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] rand_payload();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      for (int k = 0; k < N; k++) begin
         mcnt[k] = 0; mstall[k] = '0; mfull[k] = '0; mflush[k] = '0;
      end
      rst = 1'b1;
      drv(0, '0, 0, 0, 0);
      @(negedge clk);
      cycle(0);
      cycle(1);
      rst = 1'b0;

      // Post-reset: payload reads as zero on every instance.
      drv(0, '0, 0, 0, 0);
      #1;
      for (int k = 0; k < N; k++) check_eq($sformatf("d%0d_rst_data", k), out_data_w[k], '0);
      cycle(1);

      // Fill under backpressure, third push held off on DEPTH=2.
      drv(1, W'(8'hA1), 0, 0, 0); cycle(1);
      drv(1, W'(8'hA2), 0, 0, 0); cycle(1);
      drv(1, W'(8'hA3), 0, 0, 0); cycle(1);
      // Full queue with pop and push offered together: only the pop happens.
      drv(1, W'(8'hA4), 1, 0, 0); cycle(1);
      drv(0, '0, 0, 0, 0);        cycle(1);

      // Streaming push+pop across pointer wrap.
      for (int i = 0; i < 10; i++) begin
         drv(1, W'(8'h10 + i), 1, 0, 0);
         cycle(1);
      end

      // Top up, then flush while a bundle is offered.
      drv(1, W'(8'hB0), 0, 0, 0); cycle(1);
      drv(1, W'(8'hEE), 0, 0, 1); cycle(1);
      drv(0, '0, 1, 0, 0);        cycle(1);

      // Hold overrides out_ready, then releases.
      drv(1, W'(8'hC1), 0, 0, 0); cycle(1);
      for (int i = 0; i < 4; i++) begin
         drv(0, '0, 1, 1, 0);
         cycle(1);
      end
      drv(0, '0, 1, 0, 0); cycle(1);
      drv(0, '0, 1, 0, 0); cycle(1);

      // Empty-queue fall-through, consumed and then not consumed.
      drv(1, W'(8'h55), 1, 0, 0); cycle(1);
      drv(1, W'(8'h55), 0, 0, 0); cycle(1);
      drv(0, '0, 0, 0, 0);        cycle(1);
      drv(0, '0, 1, 0, 1);        cycle(1);

      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         drv($urandom_range(0, 3) != 0, rand_payload(), $urandom_range(0, 2) != 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
         cycle(1);
      end
      rst = 1'b0;
      drv(0, '0, 0, 0, 0);
      cycle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
